sprite_table_writer: RTL and testbench

CPU-side write port for the sprite attribute RAM. It assembles pairs of 16-bit CPU stores into 32-bit sprite attribute words and buffers them in a small FIFO. It drains the FIFO into the RAM write port only during vertical blank, so the scanline sprite fetch path never meets a write collision. It sits between the Q16 CPU bus decode and the write side of the dual-port RAM whose read side feeds the sprite manager.

---
 rtl/sprite_table_writer_if.sv | 24 ++
 rtl/sprite_table_writer.sv | 92 +++++++++
 tb/tb_sprite_table_writer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_table_writer_if.sv
// CPU-side store bus of the sprite attribute writer: halfword stores in,
// FIFO status (full / pending / sticky overflow) back to the CPU.
interface sprite_table_writer_if #(
  parameter int AW = 16
);
  logic          wr_en;
  logic          wr_half;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          clr_ovf;
  logic          full;
  logic          pending;
  logic          ovf;

  modport master (
    output wr_en, wr_half, wr_addr, wr_data, clr_ovf,
    input  full, pending, ovf
  );

  modport slave (
    input  wr_en, wr_half, wr_addr, wr_data, clr_ovf,
    output full, pending, ovf
  );
endinterface

// File: rtl/sprite_table_writer.sv
// Pairs 16-bit CPU stores into 32-bit sprite attribute words, queues them and
// drains the queue into the sprite RAM write port only while vblank is high.
module sprite_table_writer #(
  parameter int DEPTH = 8,
  parameter int AW    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vblank,
  sprite_table_writer_if.slave cpu,
  output logic                 ram_we,
  output logic [AW-1:0]        ram_addr,
  output logic [31:0]          ram_data
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t         state;
  state_t         nextState;
  logic [15:0]    lo;
  logic [AW+31:0] mem [DEPTH];
  logic [PW-1:0]  rdPtr;
  logic [PW-1:0]  wrPtr;
  logic [PW:0]    count;
  logic           ovfReg;
  logic           full;
  logic           commit;
  logic           push;
  logic           pop;

  // full comes from the registered count, so a pop in the same cycle never
  // makes room for a commit arriving alongside it.
  assign full   = (count == (PW+1)'(DEPTH));
  assign commit = cpu.wr_en && cpu.wr_half;
  assign push   = commit && !full;
  assign pop    = vblank && (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (pop)  nextState = WRITE;
      WRITE: if (!pop) nextState = IDLE;
    endcase
  end

  always_comb begin
    ram_we = (state == WRITE);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= {cpu.wr_addr, cpu.wr_data, lo};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo       <= '0;
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      ovfReg   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else begin
      if (cpu.wr_en && !cpu.wr_half) lo <= cpu.wr_data;
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) begin
        rdPtr                <= rdPtr + 1'b1;
        {ram_addr, ram_data} <= mem[rdPtr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A dropped commit in the same cycle as a clear keeps the flag set.
      if (commit && full)   ovfReg <= 1'b1;
      else if (cpu.clr_ovf) ovfReg <= 1'b0;
    end
  end

  assign cpu.full    = full;
  assign cpu.ovf     = ovfReg;
  assign cpu.pending = (count != '0) || ram_we;

endmodule

// File: tb/tb_sprite_table_writer.sv
// Bench for sprite_table_writer: table vectors, directed drain/overflow/reset
// sequences and random traffic compared against a queue-based reference model.
module tb_sprite_table_writer;

  localparam int DEPTH = 8;
  localparam int AW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vblank;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_data;

  int assertions = 0;
  int failures   = 0;

  logic [AW+31:0] q[$];
  logic [AW+31:0] dutLog[$];
  logic [15:0]    mLo;
  logic           mOvf;
  logic           mWe;
  logic [AW-1:0]  mAddr;
  logic [31:0]    mData;

  typedef struct {
    logic        vb;
    logic        en;
    logic        half;
    logic [15:0] addr;
    logic [15:0] data;
    logic        clr;
    logic        expWe;
    logic [15:0] expAddr;
    logic [31:0] expData;
    logic        expFull;
    logic        expPend;
    logic        expOvf;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  sprite_table_writer_if #(.AW(AW)) cpu ();

  sprite_table_writer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vblank   (vblank),
    .cpu      (cpu),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_data (ram_data)
  );

  task automatic checkValue(string name, logic [63:0] act, logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkWrite(string name, int idx, logic [AW-1:0] a, logic [31:0] d);
    assertions++;
    if (idx >= dutLog.size()) begin
      failures++;
      $display("[TB] FAIL %s: write %0d missing, only %0d writes seen", name, idx, dutLog.size());
    end else if (dutLog[idx] !== {a, d}) begin
      failures++;
      $display("[TB] FAIL %s: write %0d got 0x%0h, expected 0x%0h", name, idx, dutLog[idx], {a, d});
    end
  endtask

  task automatic applyStimulus(logic vb, logic en, logic half, logic [15:0] addr,
                               logic [15:0] data, logic clr);
    vblank      = vb;
    cpu.wr_en   = en;
    cpu.wr_half = half;
    cpu.wr_addr = addr;
    cpu.wr_data = data;
    cpu.clr_ovf = clr;
  endtask

  task automatic modelReset();
    q.delete();
    mLo   = '0;
    mOvf  = 1'b0;
    mWe   = 1'b0;
    mAddr = '0;
    mData = '0;
  endtask

  // One clock edge of the reference: pop the queue head if vblank allows,
  // then accept or drop the commit based on the occupancy seen before the edge.
  task automatic modelEdge();
    bit             wasFull;
    bit             drop;
    logic [AW+31:0] head;
    wasFull = (q.size() == DEPTH);
    drop    = 1'b0;
    if (vblank && q.size() != 0) begin
      head          = q.pop_front();
      {mAddr, mData} = head;
      mWe           = 1'b1;
    end else begin
      mWe = 1'b0;
    end
    if (cpu.wr_en && cpu.wr_half) begin
      if (wasFull) drop = 1'b1;
      else         q.push_back({cpu.wr_addr, cpu.wr_data, mLo});
    end else if (cpu.wr_en) begin
      mLo = cpu.wr_data;
    end
    if (drop)             mOvf = 1'b1;
    else if (cpu.clr_ovf) mOvf = 1'b0;
  endtask

  task automatic checkOutput(string tag);
    checkValue({tag, ".ram_we"},   ram_we,      mWe);
    checkValue({tag, ".ram_addr"}, ram_addr,    mAddr);
    checkValue({tag, ".ram_data"}, ram_data,    mData);
    checkValue({tag, ".full"},     cpu.full,    q.size() == DEPTH);
    checkValue({tag, ".pending"},  cpu.pending, (q.size() != 0) || mWe);
    checkValue({tag, ".ovf"},      cpu.ovf,     mOvf);
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    modelEdge();
    #1;
    if (ram_we === 1'b1) dutLog.push_back({ram_addr, ram_data});
    checkOutput(tag);
  endtask

  task automatic idle(logic vb, int n, string tag);
    applyStimulus(vb, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic store(logic vb, logic half, logic [15:0] addr, logic [15:0] data, string tag);
    applyStimulus(vb, 1'b1, half, addr, data, 1'b0);
    tick(tag);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b0,
                1'b0, 16'h0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 16'h0040, 16'hABCD, 1'b0,
                1'b0, 16'h0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0,
                1'b1, 16'h0040, 32'hABCD_1234, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0,
                1'b0, 16'h0040, 32'hABCD_1234, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    modelReset();
    #12;
    checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic store through the vector table.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].vb, vecs[i].en, vecs[i].half, vecs[i].addr, vecs[i].data, vecs[i].clr);
      tick("basic");
      checkValue("vec.ram_we",   ram_we,      vecs[i].expWe);
      checkValue("vec.ram_addr", ram_addr,    vecs[i].expAddr);
      checkValue("vec.ram_data", ram_data,    vecs[i].expData);
      checkValue("vec.full",     cpu.full,    vecs[i].expFull);
      checkValue("vec.pending",  cpu.pending, vecs[i].expPend);
      checkValue("vec.ovf",      cpu.ovf,     vecs[i].expOvf);
    end

    // Hold off drain until vblank, then three back-to-back writes.
    store(1'b0, 1'b0, 16'h0, 16'h5A5A, "hold");
    for (int i = 1; i <= 3; i++) store(1'b0, 1'b1, 16'(i), 16'(16'h1000 + i), "hold");
    idle(1'b0, 2, "hold");
    checkValue("hold.pending", cpu.pending, 1'b1);
    checkValue("hold.ram_we",  ram_we,      1'b0);
    dutLog.delete();
    idle(1'b1, 5, "hold_drain");
    checkValue("hold.count", dutLog.size(), 3);
    for (int i = 1; i <= 3; i++) checkWrite("hold.order", i - 1, 16'(i), {16'(16'h1000 + i), 16'h5A5A});

    // Overflow: DEPTH+1 commits with the drain held off.
    for (int i = 0; i <= DEPTH; i++) begin
      store(1'b0, 1'b1, 16'(16'h0100 + i), 16'(i), "ovf");
      if (i == DEPTH - 1) checkValue("ovf.full_after_8", cpu.full, 1'b1);
    end
    checkValue("ovf.set_after_9", cpu.ovf, 1'b1);
    dutLog.delete();
    idle(1'b1, DEPTH + 3, "ovf_drain");
    checkValue("ovf.drain_count", dutLog.size(), DEPTH);
    checkWrite("ovf.last", DEPTH - 1, 16'h0107, {16'h0007, 16'h5A5A});
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    tick("clr");
    checkValue("ovf.cleared", cpu.ovf, 1'b0);

    // vblank open for exactly two edges, then the rest on the next window.
    for (int i = 0; i < 4; i++) store(1'b0, 1'b1, 16'(16'h0200 + i), 16'(16'hC000 + i), "cut");
    dutLog.delete();
    idle(1'b1, 2, "cut");
    idle(1'b0, 3, "cut");
    checkValue("cut.first_window", dutLog.size(), 2);
    idle(1'b1, 4, "cut2");
    checkValue("cut.total", dutLog.size(), 4);
    for (int i = 0; i < 4; i++) checkWrite("cut.order", i, 16'(16'h0200 + i), {16'(16'hC000 + i), 16'h5A5A});

    // Push and pop in the same cycle while draining with one entry.
    dutLog.delete();
    for (int i = 0; i < 3; i++) store(1'b1, 1'b1, 16'(16'h0300 + i), 16'(16'hD000 + i), "pushpop");
    idle(1'b1, 3, "pushpop");
    checkValue("pushpop.count", dutLog.size(), 3);
    for (int i = 0; i < 3; i++) checkWrite("pushpop.order", i, 16'(16'h0300 + i), {16'(16'hD000 + i), 16'h5A5A});

    // Full FIFO with a pop on the same edge still drops the commit.
    for (int i = 0; i < DEPTH; i++) store(1'b0, 1'b1, 16'(16'h0400 + i), 16'(i), "fullpop");
    store(1'b1, 1'b1, 16'h04FF, 16'hEEEE, "fullpop");
    checkValue("fullpop.ovf", cpu.ovf, 1'b1);
    dutLog.delete();
    idle(1'b1, DEPTH + 2, "fullpop_drain");
    checkValue("fullpop.count", dutLog.size(), DEPTH - 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    tick("fullpop_clr");

    // Asynchronous reset in the middle of a drain, between clock edges.
    for (int i = 0; i < 3; i++) store(1'b0, 1'b1, 16'(16'h0500 + i), 16'(i), "arst");
    idle(1'b1, 1, "arst");
    checkValue("arst.we_before", ram_we, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("arst_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dutLog.delete();
    idle(1'b1, 4, "arst_after");
    checkValue("arst.no_writes", dutLog.size(), 0);
    store(1'b1, 1'b1, 16'h0055, 16'h7777, "arst_lo");
    idle(1'b1, 3, "arst_lo");
    checkWrite("arst.lo_zero", 0, 16'h0055, 32'h7777_0000);

    // Random traffic with slowly toggling vblank.
    begin
      logic vb;
      vb = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 11) == 0) vb = ~vb;
        applyStimulus(vb, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                      $urandom_range(0, 19) == 0);
        tick("random");
      end
    end
    idle(1'b1, DEPTH + 2, "final_drain");
    checkValue("final.pending", cpu.pending, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
